pkt_gen_engine: RTL and testbench

Packet-generation datapath that sits directly downstream of the AXI4-Lite `pkt_gen_controller` register block. It consumes the controller's start/stop pulses and configuration fields. It emits AXI4-Stream test frames with a fixed header and a deterministic payload, separated by a programmable idle gap. It reports a running packet count and a done pulse back to the controller's read-only registers.

---
 rtl/pkt_gen_pkg.sv | 22 ++
 rtl/pkt_gen_engine_if.sv | 31 +++
 rtl/pkt_gen_gap_timer.sv | 30 +++
 rtl/pkt_gen_engine.sv | 147 ++++++++++++++
 tb/tb_pkt_gen_engine.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_gen_pkg.sv
// Shared types and constants for the packet-generation engine.
// Also holds the beat payload formatter used by the top level.
package pkt_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } pkt_gen_state_t;

  localparam logic [15:0] PKT_MAGIC   = 16'hA55A;
  localparam int unsigned PKT_MIN_LEN = 2;

  // Beat 0 carries the magic marker and sequence number.
  // Later beats carry the sequence number and the beat index.
  function automatic logic [31:0] beat_word(input logic        first,
                                            input logic [15:0] seq,
                                            input logic [15:0] idx);
    return first ? {PKT_MAGIC, seq} : {seq, idx};
  endfunction

endpackage

// File: rtl/pkt_gen_engine_if.sv
// Configuration, stream and status bundle between the engine and its controller/sink.
// The master modport is the engine's view.
interface pkt_gen_engine_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  cfg_start;
  logic                  cfg_stop;
  logic [LEN_WIDTH-1:0]  cfg_pkt_len;
  logic [GAP_WIDTH-1:0]  cfg_gap;
  logic [CNT_WIDTH-1:0]  cfg_pkt_count;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  pkts_sent;

  modport master (
    input  cfg_start, cfg_stop, cfg_pkt_len, cfg_gap, cfg_pkt_count, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done, pkts_sent
  );

  modport slave (
    output cfg_start, cfg_stop, cfg_pkt_len, cfg_gap, cfg_pkt_count, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done, pkts_sent
  );
endinterface

// File: rtl/pkt_gen_gap_timer.sv
// Loadable down-counter timing the idle gap between packets.
// expire is high in the last counting cycle, so the owner leaves GAP on the following edge.
module pkt_gen_gap_timer #(
  parameter int unsigned GAP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [GAP_WIDTH-1:0] value,
  input  logic                 run,
  input  logic                 clear,
  output logic                 expire
);
  logic [GAP_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - GAP_WIDTH'(1);
    end
  end

  assign expire = run && (cnt_q <= GAP_WIDTH'(1));

endmodule

// File: rtl/pkt_gen_engine.sv
// AXI4-Stream test-frame generator driven by start/stop pulses from the register block.
// Frames are never truncated by stop; a stop in the gap ends the run immediately.
module pkt_gen_engine
  import pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic              ACLK,
  input logic              ARESET,
  pkt_gen_engine_if.master bus
);

  pkt_gen_state_t       state_q, state_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, len_clamped;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d, sent_inc;
  logic [15:0]          seq_q, seq_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 done_q, done_d;
  logic                 sending, xfer, last_beat;
  logic                 gap_load, gap_clear, gap_run, gap_expire;

  assign len_clamped = (bus.cfg_pkt_len < LEN_WIDTH'(PKT_MIN_LEN)) ?
                       LEN_WIDTH'(PKT_MIN_LEN) : bus.cfg_pkt_len;
  assign sending   = (state_q == StSend);
  assign xfer      = sending && bus.m_axis_tready;
  assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));
  assign sent_inc  = sent_q + CNT_WIDTH'(1);
  assign gap_run   = (state_q == StGap);

  pkt_gen_gap_timer #(
    .GAP_WIDTH(GAP_WIDTH)
  ) u_gap_timer (
    .clk   (ACLK),
    .rst   (ARESET),
    .load  (gap_load),
    .value (gap_q),
    .run   (gap_run),
    .clear (gap_clear),
    .expire(gap_expire)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    len_d       = len_q;
    gap_d       = gap_q;
    count_d     = count_q;
    sent_d      = sent_q;
    seq_d       = seq_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    gap_load    = 1'b0;
    gap_clear   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Stop beats start when both arrive together.
        if (bus.cfg_start && !bus.cfg_stop) begin
          len_d       = len_clamped;
          gap_d       = bus.cfg_gap;
          count_d     = bus.cfg_pkt_count;
          sent_d      = '0;
          seq_d       = '0;
          beat_d      = '0;
          stop_pend_d = 1'b0;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (bus.cfg_stop) stop_pend_d = 1'b1;
        if (xfer) begin
          if (last_beat) begin
            sent_d = sent_inc;
            seq_d  = seq_q + 16'd1;
            beat_d = '0;
            if (stop_pend_q || bus.cfg_stop ||
                ((count_q != '0) && (sent_inc == count_q))) begin
              state_d     = StIdle;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end else if (gap_q != '0) begin
              state_d  = StGap;
              gap_load = 1'b1;
            end
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
      StGap: begin
        if (bus.cfg_stop) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          gap_clear = 1'b1;
        end else if (gap_expire) begin
          state_d = StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      count_q     <= '0;
      sent_q      <= '0;
      seq_q       <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      sent_q      <= sent_d;
      seq_q       <= seq_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    bus.m_axis_tdata = '0;
    if (sending) begin
      bus.m_axis_tdata = DATA_WIDTH'(beat_word(beat_q == '0, seq_q, 16'(beat_q)));
    end
  end

  assign bus.m_axis_tvalid = sending;
  assign bus.m_axis_tlast  = sending && last_beat;
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = done_q;
  assign bus.pkts_sent     = sent_q;

endmodule

// File: tb/tb_pkt_gen_engine.sv
// Randomized self-checking bench for pkt_gen_engine.
// Expected frames come from a packet-level model; stream timing rules are checked per cycle.
module tb_pkt_gen_engine;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned GW = 16;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pkt_gen_engine_if #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .GAP_WIDTH (GW),
    .CNT_WIDTH (CW)
  ) bus ();

  pkt_gen_engine #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .GAP_WIDTH (GW),
    .CNT_WIDTH (CW)
  ) dut (
    .ACLK  (clk),
    .ARESET(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cfg();
    bus.cfg_pkt_len   = LW'($urandom_range(40));
    bus.cfg_gap       = GW'($urandom_range(9));
    bus.cfg_pkt_count = CW'($urandom_range(9));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
    check_eq({tag, "_tdata"}, 64'(bus.m_axis_tdata), 64'd0);
    check_eq({tag, "_tlast"}, 64'(bus.m_axis_tlast), 64'd0);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_done"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_pkts"}, 64'(bus.pkts_sent), 64'd0);
  endtask

  // One run: stop_at is the transfer index whose presentation cycle carries a stop (-1: none).
  task automatic run_txn(input int len, input int gap, input int count, input int stall_pct,
                         input int stop_at, input bit poke_start);
    logic [32:0] exp_q[$];
    logic [32:0] exp_b;
    logic [31:0] prev_d;
    logic        prev_l;
    int eff, npkts, xfers, pkts, idle, r;
    bit stalled, in_gap, finished, stop_done;

    eff = (len < 2) ? 2 : len;
    if (stop_at < 0) npkts = count;
    else if (count == 0) npkts = stop_at / eff + 1;
    else npkts = (count < stop_at / eff + 1) ? count : stop_at / eff + 1;
    for (int p = 0; p < npkts; p++) begin
      for (int k = 0; k < eff; k++) begin
        exp_b[32]    = (k == eff - 1);
        exp_b[31:0]  = (k == 0) ? {16'hA55A, 16'(p)} : {16'(p), 16'(k)};
        exp_q.push_back(exp_b);
      end
    end

    bus.cfg_pkt_len   = LW'(len);
    bus.cfg_gap       = GW'(gap);
    bus.cfg_pkt_count = CW'(count);
    bus.cfg_start     = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    scramble_cfg();
    check_eq("start_busy", 64'(bus.busy), 64'd1);

    xfers = 0; pkts = 0; idle = 0;
    stalled = 0; in_gap = 0; finished = 0; stop_done = 0;
    prev_d = '0; prev_l = 1'b0;
    for (int budget = 0; budget < 4000 && !finished; budget++) begin
      check_eq("pkts_sent_run", 64'(bus.pkts_sent), 64'(pkts));
      r = int'($urandom_range(99));
      bus.m_axis_tready = (r >= stall_pct);
      bus.cfg_start     = poke_start && ($urandom_range(7) == 0);
      bus.cfg_stop      = 1'b0;
      if (bus.m_axis_tvalid) begin
        if (in_gap) begin
          check_eq("gap_len", 64'(idle), 64'(gap));
          in_gap = 0;
        end
        if (stalled) begin
          check_eq("stall_tdata", 64'(bus.m_axis_tdata), 64'(prev_d));
          check_eq("stall_tlast", 64'(bus.m_axis_tlast), 64'(prev_l));
        end
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 64'(bus.m_axis_tdata), 64'd0);
          break;
        end
        if (!stop_done && xfers == stop_at) begin
          bus.cfg_stop = 1'b1;
          stop_done    = 1;
        end
        if (bus.m_axis_tready) begin
          exp_b = exp_q.pop_front();
          check_eq("tdata", 64'(bus.m_axis_tdata), 64'(exp_b[31:0]));
          check_eq("tlast", 64'(bus.m_axis_tlast), 64'(exp_b[32]));
          xfers++;
          stalled = 0;
          if (exp_b[32]) begin
            pkts++;
            if (exp_q.size() == 0) finished = 1;
            else if (gap > 0) begin
              in_gap = 1;
              idle   = 0;
            end
          end
        end else begin
          stalled = 1;
          prev_d  = bus.m_axis_tdata;
          prev_l  = bus.m_axis_tlast;
        end
      end else begin
        check_eq("idle_while_running", 64'(in_gap), 64'd1);
        check_eq("gap_busy", 64'(bus.busy), 64'd1);
        idle++;
      end
      step();
      bus.cfg_start = 1'b0;
      bus.cfg_stop  = 1'b0;
    end
    check_eq("run_finished", 64'(finished), 64'd1);
    check_eq("end_done", 64'(bus.done), 64'd1);
    check_eq("end_busy", 64'(bus.busy), 64'd0);
    check_eq("end_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check_eq("end_pkts", 64'(bus.pkts_sent), 64'(npkts));
    step();
    check_eq("done_pulse_width", 64'(bus.done), 64'd0);
    check_eq("pkts_hold", 64'(bus.pkts_sent), 64'(npkts));
  endtask

  initial begin
    int seen_valid;
    bit got_last;

    bus.cfg_start     = 1'b0;
    bus.cfg_stop      = 1'b0;
    bus.cfg_pkt_len   = '0;
    bus.cfg_gap       = '0;
    bus.cfg_pkt_count = '0;
    bus.m_axis_tready = 1'b1;
    #2;
    check_idle_outputs("reset");
    step();
    step();
    rst = 1'b0;
    step();
    check_idle_outputs("post_reset");

    // Single packet, gap/sequence, back-pressure, stop mid-packet, len clamp.
    run_txn(4, 0, 1, 0, -1, 1'b0);
    run_txn(2, 3, 3, 0, -1, 1'b0);
    run_txn(8, 1, 5, 30, -1, 1'b0);
    run_txn(6, 2, 0, 0, 9, 1'b0);
    run_txn(0, 1, 2, 10, -1, 1'b1);
    run_txn(1, 0, 3, 20, -1, 1'b1);

    // Start and stop together in IDLE produce nothing.
    bus.cfg_pkt_len   = LW'(4);
    bus.cfg_pkt_count = CW'(1);
    bus.cfg_start     = 1'b1;
    bus.cfg_stop      = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    bus.cfg_stop  = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      seen_valid += int'(bus.m_axis_tvalid) + int'(bus.busy);
      step();
    end
    check_eq("start_stop_idle", 64'(seen_valid), 64'd0);

    // Stop during GAP ends the run on the next edge.
    bus.cfg_pkt_len   = LW'(2);
    bus.cfg_gap       = GW'(4);
    bus.cfg_pkt_count = CW'(0);
    bus.m_axis_tready = 1'b1;
    bus.cfg_start     = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    got_last = 0;
    for (int i = 0; i < 20 && !got_last; i++) begin
      got_last = bus.m_axis_tvalid && bus.m_axis_tlast;
      step();
    end
    check_eq("gapstop_saw_last", 64'(got_last), 64'd1);
    check_eq("gapstop_in_gap", 64'(bus.m_axis_tvalid), 64'd0);
    step();
    bus.cfg_stop = 1'b1;
    step();
    bus.cfg_stop = 1'b0;
    check_eq("gapstop_done", 64'(bus.done), 64'd1);
    check_eq("gapstop_busy", 64'(bus.busy), 64'd0);
    check_eq("gapstop_pkts", 64'(bus.pkts_sent), 64'd1);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen_valid += int'(bus.m_axis_tvalid);
    end
    check_eq("gapstop_no_beat", 64'(seen_valid), 64'd0);

    // Asynchronous reset while beat 2 is presented.
    bus.cfg_pkt_len   = LW'(6);
    bus.cfg_gap       = GW'(0);
    bus.cfg_pkt_count = CW'(1);
    bus.cfg_start     = 1'b1;
    step();
    bus.cfg_start = 1'b0;
    step();
    step();
    check_eq("rst_beat2", 64'(bus.m_axis_tdata), 64'h0000_0002);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    step();
    rst = 1'b0;
    step();
    run_txn(5, 1, 2, 20, -1, 1'b0);

    // Randomized runs.
    for (int t = 0; t < 8; t++) begin
      int len, gap, cnt, stall, stop_at;
      len     = int'($urandom_range(9));
      gap     = int'($urandom_range(4));
      cnt     = int'($urandom_range(4));
      stall   = int'($urandom_range(40));
      stop_at = (cnt == 0 || $urandom_range(1) == 1) ? int'($urandom_range(30)) : -1;
      run_txn(len, gap, cnt, stall, stop_at, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
